uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the core's data-RAM bus, beside data_ram in the minimal SoPC.
//  Top-level address decode selects it via ce.
//  CPU word-stores bytes into a TX FIFO. A bit-serial FSM drains the FIFO onto txd as 8N1 frames.
//  CPU polls STATUS to see whether it can write.
// PARAMETERS
//  FIFO_DEPTH    16   TX FIFO entries; must be a power of 2 and >=2
//  BAUD_DIV_RST  434  BAUDDIV reset value, in clk cycles per bit (50 MHz / 115200)
// PORTS
//  clk     in   1   system clock; all logic on rising edge
//  rst     in   1   synchronous, active-low reset (rst==0 resets on clk edge)
//  ce      in   1   bus select for this block (from address decode)
//  we      in   1   1=write, 0=read
//  addr    in   32  byte address; only addr[3:2] decoded
//  sel     in   4   byte enables; a write needs |sel
//  data_i  in   32  write data
//  data_o  out  32  read data; combinational; 0 when ce==0
//  txd     out  1   serial output; idles high
//  tx_irq  out  1   level: FIFO empty and FSM idle
// BEHAVIOUR
//  Register map (addr[3:2]):
//   0 TXDATA  W: push data_i[7:0]. Reads return 0.
//   1 STATUS  R: [0]full [1]empty [2]busy [3]ovf [15:8]count
//             W: writing 1 to bit3 clears ovf
//   2 BAUDDIV R/W [15:0]: writes <2 store 2
//   3 reserved: R 0; writes ignored
//  Reset: txd=1, FIFO empty, ovf=0, BAUDDIV=BAUD_DIV_RST, state=IDLE, tx_irq=1.
//   Reset mid-frame aborts the frame; txd is 1 from the reset edge on.
//  Push:
//   - TXDATA write while full: dropped; ovf set (sticky).
//   - Push and pop in the same cycle: both happen, including when full.
//   - count width is $clog2(FIFO_DEPTH+1). Pointers wrap modulo FIFO_DEPTH.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE, or -> START directly if FIFO non-empty.
//   IDLE:  when FIFO non-empty, pop on the next edge and enter START. txd=0 from that edge.
//          A write at edge N gives txd low from edge N+1.
//   START: txd=0 for BAUDDIV cycles.
//   DATA:  8 bits, LSB first, BAUDDIV cycles each.
//   STOP:  txd=1 for BAUDDIV cycles.
//   busy = (state != IDLE).
//  Baud counter:
//   - Loads BAUDDIV-1 on entry to each bit and counts down. Bit ends when the counter reaches 0.
//   - A BAUDDIV write mid-bit takes effect at the next bit load. The current bit is not stretched.
//  Simultaneous TXDATA write and STATUS read in one cycle cannot occur (single bus port).
//   STATUS read reflects pre-edge state.
// CONFIGURATION
//  `UART_TX_PARITY_EN defined:
//   - Adds state PARITY between DATA and STOP; txd = ^data (even parity) for BAUDDIV cycles.
//   - STATUS[4] reads 1.
//  Not defined: no PARITY state; frames are 8N1; STATUS[4] reads 0.
// STRUCTURE
//  uart_pkg:
//   - register offset constants REG_TXDATA/REG_STATUS/REG_BAUDDIV
//   - STATUS bit indices
//   - tx_state_t enum {IDLE,START,DATA,PARITY,STOP}
//   - BAUD_DIV_MIN=2
//  Sub-module uart_tx_fifo:
//   - parameterised sync FIFO with push/pop/full/empty/count and same-cycle push+pop
//   - top holds the register decode and the FSM
// TESTING
//  1 Reset (rst=0 for 2 clk, BAUDDIV=4) -> txd=1, STATUS=0x0002, tx_irq=1.
//  2 Write TXDATA 0x55 -> txd low from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each,
//    then high 4 cycles. With `UART_TX_PARITY_EN: parity bit 0 before stop.
//  3 16 back-to-back TXDATA writes, then a 17th -> STATUS full=1, ovf=1, count=16.
//    Frames are back-to-back with no idle gap. Write STATUS 0x8 -> ovf=0.
//  4 Write BAUDDIV=1 -> reads back 2.
//    Change BAUDDIV 4->8 mid-DATA -> current bit is 4 cycles, following bits are 8.
//  5 Pull rst low mid-DATA for 1 clk -> txd=1 next edge, FIFO empty, BAUDDIV=434.
//  6 FIFO full while FSM pops; write TXDATA in the pop cycle -> accepted, no ovf, count stays 16.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_PAR     = 4;
    localparam int ST_CNT_LSB = 8;

    localparam logic [15:0] BAUD_DIV_MIN = 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic [15:0] clamp_baud(input logic [15:0] v);
        return (v < BAUD_DIV_MIN) ? BAUD_DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head byte readable combinationally while non-empty.
// Latency: push visible on pop_dat/count one clk after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_dat,
    input  logic          pop,
    output logic [7:0]    pop_dat,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push needs, so full does not block it.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TX FIFO plus 8N1 serialiser (8E1 with UART_TX_PARITY_EN).
// Latency: TXDATA write at edge N drives the start bit from edge N+1 when idle.
// Backpressure: CPU polls STATUS.full; writes while full are dropped and set sticky ovf.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    tx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shr_q, shr_d;
    logic [15:0]   baud_q, baud_d;
    logic          ovf_q, ovf_d;

    logic          wr;
    logic [1:0]    reg_sel;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          bit_end;
    logic [15:0]   bit_load;
    logic          busy;
    logic          unused_ok;

    assign unused_ok = ^{addr[31:4], addr[1:0], data_i[31:16]};

    assign reg_sel  = addr[3:2];
    assign wr       = ce && we && (|sel);
    assign push     = wr && (reg_sel == REG_TXDATA);
    assign bit_end  = (cnt_q == 16'd0);
    assign bit_load = baud_q - 16'd1;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (data_i[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        ovf_d  = ovf_q;
        baud_d = baud_q;
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (wr && (reg_sel == REG_STATUS) && data_i[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr && (reg_sel == REG_BAUDDIV)) begin
            baud_d = clamp_baud(data_i[15:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shr_q   <= '0;
            baud_q  <= BAUD_DIV_RST;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shr_q   <= shr_d;
            baud_q  <= baud_d;
            ovf_q   <= ovf_d;
        end
    end

    // Each bit reloads from the live BAUDDIV, so a mid-bit write only affects later bits.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        pop     = 1'b0;
        cnt_d   = (state_q != IDLE && !bit_end) ? cnt_q - 16'd1 : cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shr_d   = fifo_dat;
                    cnt_d   = bit_load;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    cnt_d   = bit_load;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = bit_load;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = bit_load;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shr_d   = fifo_dat;
                        cnt_d   = bit_load;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shr_q[bit_q];
            PARITY:  txd = ^shr_q;
            default: txd = 1'b1;
        endcase
        busy   = (state_q != IDLE);
        tx_irq = fifo_empty && !busy;
    end

    always_comb begin
        data_o = '0;
        if (ce) begin
            case (reg_sel)
                REG_STATUS: begin
                    data_o[ST_FULL]             = fifo_full;
                    data_o[ST_EMPTY]            = fifo_empty;
                    data_o[ST_BUSY]             = busy;
                    data_o[ST_OVF]              = ovf_q;
                    data_o[ST_PAR]              = PAR_EN;
                    data_o[ST_CNT_LSB +: CW]    = fifo_count;
                end
                REG_BAUDDIV: data_o[15:0] = baud_q;
                default:     data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bus driver, serial-line decoder and byte scoreboard.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        txd;
    logic        tx_irq;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] baud_tb  = 16'd434;
    logic [15:0] baud_pre = 16'd434;
    bit          b2b_chk = 1'b0;
    int          idle_cnt = 0;

`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR = 32'h10;
    localparam int          NB  = 11;
`else
    localparam logic [31:0] PAR = 32'h0;
    localparam int          NB  = 10;
`endif

    uart_tx_mmio #(
        .FIFO_DEPTH   (16),
        .BAUD_DIV_RST (16'd434)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .txd    (txd),
        .tx_irq (tx_irq)
    );

    always #5 clk = ~clk;

    // Reference BAUDDIV; baud_pre is the value a bit starting at this edge loads.
    always @(posedge clk) begin
        baud_pre <= baud_tb;
        if (!rst)
            baud_tb <= 16'd434;
        else if (ce && we && (|sel) && addr[3:2] == 2'd2)
            baud_tb <= (data_i[15:0] < 16'd2) ? 16'd2 : data_i[15:0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; sel = 4'hF;
        addr = {28'h0, r, 2'b00};
        data_i = d;
        tick();
        ce = 1'b0; we = 1'b0; sel = 4'h0; data_i = '0;
    endtask

    task automatic wr_tx(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        bus_wr(2'd0, {24'h0, b});
    endtask

    task automatic bus_rd(input logic [1:0] r, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; sel = 4'hF;
        addr = {28'h0, r, 2'b00};
        #1;
        d = data_o;
        ce = 1'b0; sel = 4'h0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_irq !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", {31'h0, n < budget}, 32'h1);
    endtask

    // Serial decoder: samples every cycle of every bit, pops the scoreboard per frame.
    initial begin : monitor
        int         blen;
        logic       v;
        logic       pv;
        bit         bad;
        bit         abort;
        logic [7:0] shreg;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (txd !== 1'b0 || rst !== 1'b1) begin
                idle_cnt++;
                continue;
            end
            if (b2b_chk) chk("no_gap", idle_cnt, 0);
            bad = 0; abort = 0; shreg = '0; pv = 1'b0;
            for (int b = 0; b < NB && !abort; b++) begin
                blen = int'(baud_pre);
                v = txd;
                for (int k = 0; k < blen; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst !== 1'b1) begin abort = 1; break; end
                    if (txd !== v) bad = 1;
                end
                if (b == 0 && v !== 1'b0) bad = 1;
                if (b >= 1 && b <= 8) shreg[b-1] = v;
                if (NB == 11 && b == 9) pv = v;
                if (b == NB - 1 && v !== 1'b1) bad = 1;
                if (b < NB - 1 && !abort) @(negedge clk);
            end
            idle_cnt = 0;
            if (!abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {24'h0, shreg}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_data", {23'h0, bad, shreg}, {24'h0, e});
                    if (NB == 11) chk("frame_parity", {31'h0, pv}, {31'h0, ^e});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;

        // Reset and register defaults
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_txd", {31'h0, txd}, 32'h1);
        chk("reset_irq", {31'h0, tx_irq}, 32'h1);
        bus_rd(2'd1, rd); chk("reset_status", rd, 32'h2 | PAR);
        bus_rd(2'd2, rd); chk("reset_bauddiv", rd, 32'd434);
        bus_wr(2'd2, 32'd4);
        bus_rd(2'd2, rd); chk("bauddiv_4", rd, 32'd4);
        bus_rd(2'd0, rd); chk("txdata_reads_0", rd, 32'h0);
        bus_rd(2'd3, rd); chk("reserved_reads_0", rd, 32'h0);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        bus_rd(2'd2, rd); chk("reserved_wr_ignored", rd, 32'd4);

        // Single frame, first-edge latency
        wr_tx(8'h55, 1);
        chk("pre_start_txd", {31'h0, txd}, 32'h1);
        bus_rd(2'd1, rd); chk("status_queued", rd, 32'h0100 | PAR);
        tick();
        chk("start_txd", {31'h0, txd}, 32'h0);
        chk("busy_irq", {31'h0, tx_irq}, 32'h0);
        bus_rd(2'd1, rd); chk("status_busy", rd, 32'h0006 | PAR);
        wait_drain(200);

        // Fill behind an in-flight frame, overflow, clear, back-to-back drain
        wr_tx(8'h3C, 1);
        for (int i = 0; i < 16; i++) wr_tx(8'(i * 37 + 11), 1);
        bus_rd(2'd1, rd); chk("status_full", rd, 32'h1005 | PAR);
        wr_tx(8'hEE, 0);
        bus_rd(2'd1, rd); chk("status_ovf", rd, 32'h100D | PAR);
        bus_wr(2'd1, 32'h8);
        bus_rd(2'd1, rd); chk("ovf_cleared", rd, 32'h1005 | PAR);
        b2b_chk = 1'b1;
        wait_drain(2000);
        b2b_chk = 1'b0;

        // BAUDDIV clamp, then a mid-bit rate change
        bus_wr(2'd2, 32'd1);
        bus_rd(2'd2, rd); chk("bauddiv_clamp", rd, 32'd2);
        bus_wr(2'd2, 32'd0);
        bus_rd(2'd2, rd); chk("bauddiv_clamp0", rd, 32'd2);
        bus_wr(2'd2, 32'd4);
        wr_tx(8'hA5, 1);
        repeat (10) tick();
        bus_wr(2'd2, 32'd8);
        wr_tx(8'h96, 1);
        wait_drain(400);
        bus_wr(2'd2, 32'd4);

        // Reset mid-frame
        wr_tx(8'h0F, 1);
        repeat (6) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        chk("rst_mid_txd", {31'h0, txd}, 32'h1);
        chk("rst_mid_irq", {31'h0, tx_irq}, 32'h1);
        bus_rd(2'd1, rd); chk("rst_mid_status", rd, 32'h2 | PAR);
        bus_rd(2'd2, rd); chk("rst_mid_bauddiv", rd, 32'd434);
        repeat (20) tick();
        chk("rst_mid_txd_idle", {31'h0, txd}, 32'h1);
        bus_wr(2'd2, 32'd4);

        // Push into a full FIFO on the cycle the serialiser pops
        wr_tx(8'h00, 1);
        for (int i = 0; i < 16; i++) wr_tx(8'($urandom_range(0, 255)), 1);
        begin
            int n;
            n = 0;
            while (txd !== 1'b1 && n < 100) begin tick(); n++; end
            chk("stop_seen", {31'h0, n < 100}, 32'h1);
        end
        repeat (3) tick();
        wr_tx(8'hC3, 1);
        bus_rd(2'd1, rd); chk("full_push_pop", rd, 32'h1005 | PAR);
        wait_drain(2000);
        bus_rd(2'd1, rd); chk("final_status", rd, 32'h2 | PAR);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
